// File: rtl/mem_writeback_ctrl.sv
// mem_writeback_ctrl: register-file write port and data-memory
// load/store sequencer for the 8-bit single-cycle CPU.
//
// Ports:
//   CLK, RESET (async, active low)
//   VALID, ALURESULT, STOREDATA, DEST, REG_WRITE, MEM_READ, MEM_WRITE
//     instruction side, from ALU/control
//   STALL  hold PC/instruction while a memory access is pending
//   M_READ, M_WRITE, M_ADDRESS, M_WRITEDATA, M_READDATA, M_BUSYWAIT
//     data-memory handshake
//   RF_IN, RF_INADDRESS, RF_WRITE  register-file write port
//   ERR    sticky memory timeout flag
//
// Optional macro MEM_WRITEBACK_TIMEOUT_EN: abort a memory access
// after TIMEOUT busy cycles and raise ERR. Undefined: wait forever,
// ERR tied low.
module mem_writeback_ctrl #(
  parameter int DATA_W  = 8,
  parameter int ADDR_W  = 8,
  parameter int REG_AW  = 3,
  parameter int TIMEOUT = 255
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              VALID,
  input  logic [DATA_W-1:0] ALURESULT,
  input  logic [DATA_W-1:0] STOREDATA,
  input  logic [REG_AW-1:0] DEST,
  input  logic              REG_WRITE,
  input  logic              MEM_READ,
  input  logic              MEM_WRITE,
  output logic              STALL,
  output logic              M_READ,
  output logic              M_WRITE,
  output logic [ADDR_W-1:0] M_ADDRESS,
  output logic [DATA_W-1:0] M_WRITEDATA,
  input  logic [DATA_W-1:0] M_READDATA,
  input  logic              M_BUSYWAIT,
  output logic [DATA_W-1:0] RF_IN,
  output logic [REG_AW-1:0] RF_INADDRESS,
  output logic              RF_WRITE,
  output logic              ERR
);

  if (TIMEOUT < 1 || TIMEOUT > 255) begin : g_bad_timeout
    $error("TIMEOUT must be 1..255");
  end

  typedef enum logic [1:0] {
    S_IDLE,
    S_MEM,
    S_DONE
  } state_t;

  state_t            state;
  logic [REG_AW-1:0] dest_q;
  logic              regw_q;
  logic              mem_req;
  logic              alu_wr;

  assign mem_req = VALID & (MEM_READ | MEM_WRITE);
  assign alu_wr  = VALID & REG_WRITE
                 & ~(MEM_READ | MEM_WRITE);

  // Gated by RESET so the stall drops the moment reset asserts,
  // even while the CPU still presents a memory instruction.
  assign STALL = RESET
    & (((state == S_IDLE) & mem_req)
       | (state == S_MEM));

`ifdef MEM_WRITEBACK_TIMEOUT_EN
  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

  logic [7:0] tmo_cnt;
  logic       err_q;

  assign ERR = err_q;
`else
  assign ERR = 1'b0;
`endif

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state        <= S_IDLE;
      M_READ       <= 1'b0;
      M_WRITE      <= 1'b0;
      M_ADDRESS    <= '0;
      M_WRITEDATA  <= '0;
      RF_IN        <= '0;
      RF_INADDRESS <= '0;
      RF_WRITE     <= 1'b0;
      dest_q       <= '0;
      regw_q       <= 1'b0;
`ifdef MEM_WRITEBACK_TIMEOUT_EN
      tmo_cnt      <= '0;
      err_q        <= 1'b0;
`endif
    end else begin
      RF_WRITE <= 1'b0;
      unique case (state)
        S_IDLE: begin
          unique case (1'b1)
            mem_req: begin
              M_ADDRESS   <= ADDR_W'(ALURESULT);
              M_WRITEDATA <= STOREDATA;
              dest_q      <= DEST;
              regw_q      <= REG_WRITE;
              // read wins when both are requested
              M_READ      <= MEM_READ;
              M_WRITE     <= ~MEM_READ & MEM_WRITE;
              state       <= S_MEM;
`ifdef MEM_WRITEBACK_TIMEOUT_EN
              tmo_cnt     <= '0;
`endif
            end
            alu_wr: begin
              RF_WRITE     <= 1'b1;
              RF_IN        <= ALURESULT;
              RF_INADDRESS <= DEST;
            end
            default: ;
          endcase
        end
        S_MEM: begin
          if (!M_BUSYWAIT) begin
            M_READ  <= 1'b0;
            M_WRITE <= 1'b0;
            state   <= S_DONE;
            if (M_READ && regw_q) begin
              RF_WRITE     <= 1'b1;
              RF_IN        <= M_READDATA;
              RF_INADDRESS <= dest_q;
            end
          end
`ifdef MEM_WRITEBACK_TIMEOUT_EN
          else if (tmo_cnt == TMO_LAST) begin
            M_READ  <= 1'b0;
            M_WRITE <= 1'b0;
            err_q   <= 1'b1;
            state   <= S_DONE;
          end else begin
            tmo_cnt <= tmo_cnt + 8'd1;
          end
`endif
        end
        // CPU re-presents the finished instruction here; ignore it.
        S_DONE: state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_writeback_ctrl.sv
// tb_mem_writeback_ctrl: directed vector table plus hand sequences
// for reset, stuck-busy memory and optional timeout.
module tb_mem_writeback_ctrl;

  logic       CLK = 1'b0;
  logic       RESET;
  logic       VALID;
  logic [7:0] ALURESULT;
  logic [7:0] STOREDATA;
  logic [2:0] DEST;
  logic       REG_WRITE;
  logic       MEM_READ;
  logic       MEM_WRITE;
  logic       STALL;
  logic       M_READ;
  logic       M_WRITE;
  logic [7:0] M_ADDRESS;
  logic [7:0] M_WRITEDATA;
  logic [7:0] M_READDATA;
  logic       M_BUSYWAIT;
  logic [7:0] RF_IN;
  logic [2:0] RF_INADDRESS;
  logic       RF_WRITE;
  logic       ERR;

  int checks = 0;
  int errors = 0;

  always #5 CLK = ~CLK;

  mem_writeback_ctrl #(
    .DATA_W (8),
    .ADDR_W (8),
    .REG_AW (3),
    .TIMEOUT(4)
  ) dut (
    .CLK         (CLK),
    .RESET       (RESET),
    .VALID       (VALID),
    .ALURESULT   (ALURESULT),
    .STOREDATA   (STOREDATA),
    .DEST        (DEST),
    .REG_WRITE   (REG_WRITE),
    .MEM_READ    (MEM_READ),
    .MEM_WRITE   (MEM_WRITE),
    .STALL       (STALL),
    .M_READ      (M_READ),
    .M_WRITE     (M_WRITE),
    .M_ADDRESS   (M_ADDRESS),
    .M_WRITEDATA (M_WRITEDATA),
    .M_READDATA  (M_READDATA),
    .M_BUSYWAIT  (M_BUSYWAIT),
    .RF_IN       (RF_IN),
    .RF_INADDRESS(RF_INADDRESS),
    .RF_WRITE    (RF_WRITE),
    .ERR         (ERR)
  );

  typedef struct {
    logic       v, rw, mr, mw;
    logic [7:0] alu, sd;
    logic [2:0] dst;
    logic       busy;
    logic [7:0] rdata;
    logic       e_stall, e_rfw;
    logic [2:0] e_ra;
    logic [7:0] e_rin;
    logic       e_mr, e_mw;
    logic [7:0] e_addr, e_wd;
  } vec_t;

  localparam int NV = 20;
  vec_t tv[NV];

  function automatic vec_t mk(
    logic v, logic rw, logic mr, logic mw,
    logic [7:0] alu, logic [7:0] sd, logic [2:0] dst,
    logic busy, logic [7:0] rdata,
    logic e_stall, logic e_rfw, logic [2:0] e_ra,
    logic [7:0] e_rin, logic e_mr, logic e_mw,
    logic [7:0] e_addr, logic [7:0] e_wd);
    vec_t t;
    t.v = v; t.rw = rw; t.mr = mr; t.mw = mw;
    t.alu = alu; t.sd = sd; t.dst = dst;
    t.busy = busy; t.rdata = rdata;
    t.e_stall = e_stall; t.e_rfw = e_rfw;
    t.e_ra = e_ra; t.e_rin = e_rin;
    t.e_mr = e_mr; t.e_mw = e_mw;
    t.e_addr = e_addr; t.e_wd = e_wd;
    return t;
  endfunction

  task automatic chk(string name, logic [31:0] act,
                     logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h",
               name, act, exp);
    end
  endtask

  task automatic drive(logic v, logic rw, logic mr,
                       logic mw, logic [7:0] alu,
                       logic [7:0] sd, logic [2:0] dst,
                       logic busy, logic [7:0] rdata);
    VALID = v; REG_WRITE = rw;
    MEM_READ = mr; MEM_WRITE = mw;
    ALURESULT = alu; STOREDATA = sd; DEST = dst;
    M_BUSYWAIT = busy; M_READDATA = rdata;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit");
    $fatal(1);
  end

  initial begin
    int n;
    // v rw mr mw alu sd dst busy rdata |
    // stall rfw ra rin mr mw addr wd
    tv[0]  = mk(0,0,0,0,8'h00,8'h00,0,0,8'h00,
                0,0,0,8'h00,0,0,8'h00,8'h00);
    tv[1]  = mk(1,1,0,0,8'h2A,8'h00,3,0,8'h00,
                0,1,3,8'h2A,0,0,8'h00,8'h00);
    tv[2]  = mk(1,1,0,0,8'h11,8'h00,5,0,8'h00,
                0,1,5,8'h11,0,0,8'h00,8'h00);
    tv[3]  = mk(1,0,0,0,8'h99,8'h00,4,0,8'h00,
                0,0,0,8'h00,0,0,8'h00,8'h00);
    tv[4]  = mk(1,1,1,0,8'h40,8'h00,2,1,8'h00,
                1,0,0,8'h00,1,0,8'h40,8'h00);
    tv[5]  = mk(1,1,1,0,8'h40,8'h00,2,1,8'h00,
                1,0,0,8'h00,1,0,8'h40,8'h00);
    tv[6]  = mk(1,1,1,0,8'h40,8'h00,2,1,8'h00,
                1,0,0,8'h00,1,0,8'h40,8'h00);
    tv[7]  = mk(1,1,1,0,8'h40,8'h00,2,1,8'h00,
                1,0,0,8'h00,1,0,8'h40,8'h00);
    tv[8]  = mk(1,1,1,0,8'h40,8'h00,2,0,8'h9C,
                1,1,2,8'h9C,0,0,8'h00,8'h00);
    tv[9]  = mk(1,1,0,0,8'h55,8'h00,7,0,8'h00,
                0,0,0,8'h00,0,0,8'h00,8'h00);
    tv[10] = mk(1,0,0,1,8'h10,8'h77,0,0,8'h00,
                1,0,0,8'h00,0,1,8'h10,8'h77);
    tv[11] = mk(1,0,0,1,8'h10,8'h77,0,0,8'h00,
                1,0,0,8'h00,0,0,8'h00,8'h00);
    tv[12] = mk(1,0,0,1,8'h10,8'h77,0,0,8'h00,
                0,0,0,8'h00,0,0,8'h00,8'h00);
    tv[13] = mk(1,1,1,1,8'h20,8'h00,1,0,8'h00,
                1,0,0,8'h00,1,0,8'h20,8'h00);
    tv[14] = mk(1,1,1,1,8'h20,8'h00,1,0,8'h05,
                1,1,1,8'h05,0,0,8'h00,8'h00);
    tv[15] = mk(1,1,1,1,8'h20,8'h00,1,0,8'h05,
                0,0,0,8'h00,0,0,8'h00,8'h00);
    tv[16] = mk(1,0,1,0,8'h33,8'h00,6,0,8'h00,
                1,0,0,8'h00,1,0,8'h33,8'h00);
    tv[17] = mk(1,0,1,0,8'h33,8'h00,6,0,8'hAA,
                1,0,0,8'h00,0,0,8'h00,8'h00);
    tv[18] = mk(1,0,1,0,8'h33,8'h00,6,0,8'hAA,
                0,0,0,8'h00,0,0,8'h00,8'h00);
    tv[19] = mk(0,0,0,0,8'h00,8'h00,0,0,8'h00,
                0,0,0,8'h00,0,0,8'h00,8'h00);

    RESET = 1'b0;
    drive(0,0,0,0,8'h00,8'h00,0,0,8'h00);
    repeat (2) @(posedge CLK);
    #1;
    chk("rst_stall", STALL, 0);
    chk("rst_mread", M_READ, 0);
    chk("rst_mwrite", M_WRITE, 0);
    chk("rst_rfw", RF_WRITE, 0);
    chk("rst_err", ERR, 0);
    chk("rst_maddr", M_ADDRESS, 0);
    chk("rst_rfin", RF_IN, 0);
    chk("rst_rfaddr", RF_INADDRESS, 0);
    @(negedge CLK);
    RESET = 1'b1;

    for (int i = 0; i < NV; i++) begin
      @(negedge CLK);
      drive(tv[i].v, tv[i].rw, tv[i].mr, tv[i].mw,
            tv[i].alu, tv[i].sd, tv[i].dst,
            tv[i].busy, tv[i].rdata);
      #1;
      chk($sformatf("v%0d_stall", i), STALL,
          tv[i].e_stall);
      @(posedge CLK);
      #1;
      chk($sformatf("v%0d_rfw", i), RF_WRITE,
          tv[i].e_rfw);
      chk($sformatf("v%0d_mread", i), M_READ,
          tv[i].e_mr);
      chk($sformatf("v%0d_mwrite", i), M_WRITE,
          tv[i].e_mw);
      chk($sformatf("v%0d_err", i), ERR, 0);
      if (tv[i].e_rfw) begin
        chk($sformatf("v%0d_rfaddr", i), RF_INADDRESS,
            tv[i].e_ra);
        chk($sformatf("v%0d_rfin", i), RF_IN,
            tv[i].e_rin);
      end
      if (tv[i].e_mr || tv[i].e_mw)
        chk($sformatf("v%0d_maddr", i), M_ADDRESS,
            tv[i].e_addr);
      if (tv[i].e_mw)
        chk($sformatf("v%0d_mwdata", i), M_WRITEDATA,
            tv[i].e_wd);
    end

    // async reset in the middle of a load
    @(negedge CLK);
    drive(1,1,1,0,8'h60,8'h00,2,1,8'h00);
    @(posedge CLK);
    #1;
    chk("mid_load_mread", M_READ, 1);
    #2;
    RESET = 1'b0;
    #1;
    chk("arst_mread", M_READ, 0);
    chk("arst_stall", STALL, 0);
    chk("arst_rfw", RF_WRITE, 0);
    chk("arst_err", ERR, 0);
    chk("arst_maddr", M_ADDRESS, 0);
    @(negedge CLK);
    drive(0,0,0,0,8'h00,8'h00,0,0,8'h00);
    RESET = 1'b1;
    @(negedge CLK);
    drive(1,1,0,0,8'h3C,8'h00,4,0,8'h00);
    #1;
    chk("post_rst_stall", STALL, 0);
    @(posedge CLK);
    #1;
    chk("post_rst_rfw", RF_WRITE, 1);
    chk("post_rst_rfaddr", RF_INADDRESS, 4);
    chk("post_rst_rfin", RF_IN, 8'h3C);

`ifdef MEM_WRITEBACK_TIMEOUT_EN
    // stuck busy: abort after 4 MEM cycles
    @(negedge CLK);
    drive(1,1,1,0,8'h44,8'h00,3,1,8'h00);
    n = 0;
    for (int k = 0; k < 20; k++) begin
      @(posedge CLK);
      #1;
      if (!M_READ) break;
      n++;
    end
    chk("tmo_cycles", n, 4);
    chk("tmo_err", ERR, 1);
    chk("tmo_rfw", RF_WRITE, 0);
    chk("tmo_stall", STALL, 0);
    @(negedge CLK);
    drive(1,1,0,0,8'h5A,8'h00,6,0,8'h00);
    @(posedge CLK);
    #1;
    chk("tmo_done_rfw", RF_WRITE, 0);
    @(posedge CLK);
    #1;
    chk("tmo_alu_rfw", RF_WRITE, 1);
    chk("tmo_alu_rfaddr", RF_INADDRESS, 6);
    chk("tmo_alu_rfin", RF_IN, 8'h5A);
    chk("tmo_err_sticky", ERR, 1);
`else
    // stuck busy: wait indefinitely, no error
    @(negedge CLK);
    drive(1,1,1,0,8'h44,8'h00,3,1,8'h00);
    n = 0;
    for (int k = 0; k < 12; k++) begin
      @(posedge CLK);
      #1;
      if (M_READ) n++;
    end
    chk("wait_cycles", n, 12);
    chk("wait_err", ERR, 0);
    chk("wait_stall", STALL, 1);
    @(negedge CLK);
    drive(1,1,1,0,8'h44,8'h00,3,0,8'h3E);
    @(posedge CLK);
    #1;
    chk("wait_rfw", RF_WRITE, 1);
    chk("wait_rfaddr", RF_INADDRESS, 3);
    chk("wait_rfin", RF_IN, 8'h3E);
    chk("wait_mread", M_READ, 0);
    @(negedge CLK);
    drive(0,0,0,0,8'h00,8'h00,0,0,8'h00);
    @(posedge CLK);
    #1;
    chk("wait_done_rfw", RF_WRITE, 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
